// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, blank
// patterns and the active-low hex-to-segment table.
package seg7_pkg;

    localparam int SEG7_DIGITS = 8;
    localparam logic [7:0] SEG7_BLANK  = 8'hFF;
    localparam logic [7:0] SEG7_AN_OFF = 8'hFF;

    // Entry n is the active-low segment byte for hex digit n; bit 7 (dp) stays high.
    localparam logic [15:0][7:0] SEG7_HEX_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (dp off).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = SEG7_HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Memory-mapped 8-digit common-anode display scanner with registered outputs.
// Optional leading-zero suppression is enabled by defining SEG7_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg7_cs,
    input  logic [31:0] wdata,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [31:0]   data_r;
    logic [PW-1:0] presc_r;
    logic [2:0]    idx_r;
    logic [7:0]    seg_r;
    logic [7:0]    an_r;

    logic          tick_s;
    logic [2:0]    next_idx_s;
    logic [3:0]    nibble_s;
    logic [7:0]    dec_seg_s;
    logic [7:0]    next_seg_s;
    logic [7:0]    next_an_s;
    logic          blank_s;

    // Slot timing and selection of the digit that becomes visible on the next tick.
    always_comb begin
        tick_s     = (presc_r == PRESC_MAX);
        next_idx_s = idx_r + 3'd1;
        nibble_s   = data_r[{next_idx_s, 2'b00} +: 4];
        next_an_s  = ~(8'b0000_0001 << next_idx_s);
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble_s),
        .seg    (dec_seg_s)
    );

    // Leading-zero blanking: a digit above 0 is dark when it and every higher nibble are zero.
    always_comb begin
        blank_s = 1'b0;
`ifdef SEG7_ZERO_BLANK_EN
        if ((next_idx_s != 3'd0) && ((data_r >> {next_idx_s, 2'b00}) == 32'd0)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
`endif
        if (blank_s) begin
            next_seg_s = SEG7_BLANK;
        end else begin
            next_seg_s = dec_seg_s;
        end
    end

    // Data register: every strobed write lands in one cycle, last write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= 32'd0;
        end else if (seg7_cs) begin
            data_r <= wdata;
        end
    end

    // Prescaler wraps at CLK_DIV-1, defining one digit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Index starts at 7 so the first tick after reset lights digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= 3'd7;
            an_r  <= SEG7_AN_OFF;
            seg_r <= SEG7_BLANK;
        end else if (tick_s) begin
            idx_r <= next_idx_s;
            an_r  <= next_an_s;
            seg_r <= next_seg_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (CLK_DIV=4): a cycle-level reference
// model pushes the expected (an,seg) pair each edge; a monitor pops and compares.
module tb_seg7_scan_driver;

    localparam int CLK_DIV = 4;

    logic        clk;
    logic        rst;
    logic        seg7_cs;
    logic [31:0] wdata;
    logic [7:0]  seg;
    logic [7:0]  an;

    int n_vec = 0;
    int n_err = 0;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg7_cs (seg7_cs),
        .wdata   (wdata),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Reference model state: edges since reset release, data, displayed pair.
    int          t = 0;
    logic [31:0] m_data = 32'd0;
    logic [7:0]  m_an = 8'hFF;
    logic [7:0]  m_seg = 8'hFF;
    logic [15:0] sb_q [$];

    function automatic logic [7:0] expect_seg(input logic [31:0] d, input int digit);
        logic [31:0] upper;
        upper = d >> (4 * digit);
`ifdef SEG7_ZERO_BLANK_EN
        if (digit >= 1 && upper == 32'd0) return 8'hFF;
`endif
        return hex_tab[upper[3:0]];
    endfunction

    always @(posedge clk) begin : model
        int          nt;
        int          digit;
        logic [7:0]  n_an;
        logic [7:0]  n_seg;
        logic [31:0] n_data;
        if (rst) begin
            nt = 0; n_an = 8'hFF; n_seg = 8'hFF; n_data = 32'd0;
        end else begin
            nt = t + 1;
            n_an = m_an; n_seg = m_seg; n_data = m_data;
            if (nt % CLK_DIV == 0) begin
                digit = ((nt / CLK_DIV) - 1) % 8;
                n_an  = ~(8'h01 << digit);
                n_seg = expect_seg(m_data, digit);
            end
            if (seg7_cs) n_data = wdata;
        end
        t      <= nt;
        m_an   <= n_an;
        m_seg  <= n_seg;
        m_data <= n_data;
        sb_q.push_back({n_an, n_seg});
    end

    // Monitor: one registered output pair per edge, compared half a cycle later.
    always @(negedge clk) begin : monitor
        logic [15:0] exp_pair;
        if (sb_q.size() != 0) begin
            exp_pair = sb_q.pop_front();
            n_vec = n_vec + 1;
            if ({an, seg} !== exp_pair)
                $display("FAIL an_seg @%0t: got an=%h seg=%h, expected an=%h seg=%h",
                         $time, an, seg, exp_pair[15:8], exp_pair[7:0]);
            if ({an, seg} !== exp_pair) n_err = n_err + 1;
        end
    end

    task automatic cs_write(input logic [31:0] d);
        seg7_cs = 1'b1;
        wdata   = d;
        @(negedge clk);
        seg7_cs = 1'b0;
        wdata   = $urandom;
    endtask

    task automatic wait_pre_tick();
        int guard = 0;
        while (((t + 1) % CLK_DIV) != 0 && guard < 4 * CLK_DIV) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_scan(input int scans);
        repeat (scans * 8 * CLK_DIV) @(negedge clk);
    endtask

    initial begin : stimulus
        int guard;
        int r;
        rst = 1'b1; seg7_cs = 1'b0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_scan(1);

        cs_write(32'h1234_5678);
        wait_scan(2);

        // Write coincident with a tick: that slot uses the old data.
        cs_write(32'h0000_0000);
        wait_scan(1);
        wait_pre_tick();
        cs_write(32'hFFFF_FFFF);
        wait_scan(1);

        // Back-to-back strobes, last one wins.
        seg7_cs = 1'b1;
        wdata = 32'h1; @(negedge clk);
        wdata = 32'h2; @(negedge clk);
        wdata = 32'hA; @(negedge clk);
        seg7_cs = 1'b0;
        wait_scan(1);

        cs_write(32'h0000_00A0);
        wait_scan(1);
        cs_write(32'h0000_0000);
        wait_scan(1);

        // Reset while digit 5 is lit, with a coincident write that must be dropped.
        cs_write(32'hDEAD_BEEF);
        guard = 0;
        while (m_an != 8'hDF && guard < 16 * CLK_DIV) begin
            @(negedge clk);
            guard++;
        end
        if (m_an != 8'hDF) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL digit5_wait: got timeout, expected digit 5 slot");
        end
        rst = 1'b1; seg7_cs = 1'b1; wdata = 32'h7654_3210;
        @(negedge clk);
        rst = 1'b0; seg7_cs = 1'b0;
        wait_scan(1);

        // Random traffic with sparse writes (often leading zeros) and rare resets.
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 199);
            rst     = (r < 2);
            seg7_cs = (r >= 193);
            wdata   = $urandom >> $urandom_range(0, 31);
            @(negedge clk);
        end
        rst = 1'b0; seg7_cs = 1'b0;
        wait_scan(1);

        @(negedge clk);
        #1;
        n_vec = n_vec + 1;
        if (sb_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Memory-mapped seven-segment display responder on the CPU I/O bus. It accepts 32-bit writes qualified by the decoded `seg7_cs` strobe and latches them as eight hex nibbles. It continuously time-multiplexes those nibbles onto an 8-digit common-anode display. It sits between the I/O address decoder and the board pins.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot. Legal range is ≥ 2.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `seg7_cs`  input  1  write strobe, already qualified by address, chip select and write.
- `wdata`  input  32  CPU write data. Nibble *i* is shown on digit *i*; digit 0 is the rightmost.
- `seg`  output  8  segment drive, active-low: `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp.
- `an`  output  8  digit enables, active-low, one-hot-low. `an[i]` drives digit *i*.

## Operation
- **Data register (32 bit).**
  - Loaded with `wdata` on any edge where `seg7_cs`=1.
  - Back-to-back strobes: the last write wins. There is no handshake and no stall; every write completes in one cycle.
- **Prescaler.**
  - Counts 0..`CLK_DIV`-1, then wraps to 0.
  - `tick` is high when the count equals `CLK_DIV`-1.
- **Digit index (3 bit).**
  - Advances on `tick`, wrapping 7→0.
- **Outputs are registered and updated only on `tick`:**
  - `an` ← ~(1 << next_index).
  - `seg` ← decode(nibble[next_index]).
- **Decimal point:** always off (`seg[7]`=1).
- **Hex decode** (active-low, value given as full `seg` byte):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E
- **Reset values:**
  - Data register = 0.
  - Prescaler = 0.
  - Index = 7.
  - `an`=8'hFF (all digits off).
  - `seg`=8'hFF.
- **Reset mid-scan:** overrides everything, including a coincident `seg7_cs`. Outputs go blank on the next edge.

## Timing
- **First display after reset release:** the first `tick` occurs `CLK_DIV` cycles after release. On that edge the display shows digit 0 (`an`=FE).
- **Refresh period:** 8×`CLK_DIV` cycles for a full scan; each digit is lit for exactly `CLK_DIV` cycles.
- **Write/display latency:**
  - A write becomes visible at the first `tick` strictly after the write edge.
  - If a write and a `tick` fall on the same edge, the outputs use the **old** data.
- **Glitch-free outputs:** `seg` and `an` change on the same edge. No combinational path from any input to any output.

## Configuration
- **`SEG7_ZERO_BLANK_EN` defined:**
  - Leading-zero suppression. Digit *i* (*i*≥1) shows `seg`=FF when nibble *i* and all higher nibbles are 0.
  - `an` still scans normally.
  - Digit 0 is never blanked.
- **Not defined:** all 8 digits always show their hex value, including leading zeros.

## Structure
- **Package `seg7_pkg`:**
  - `SEG7_DIGITS`=8
  - `SEG7_BLANK`=8'hFF
  - `SEG7_AN_OFF`=8'hFF
  - Hex→segment constant table
- **Sub-module `seg7_hex_decode`:** combinational, 4-bit nibble in, 8-bit active-low `seg` out. Instantiated once and fed by the selected nibble of the next index.
- **Top holds:** data register, prescaler, index counter, blanking logic and output registers.

## Test plan
All scenarios use `CLK_DIV`=4.
- **Reset:**
  - Stimulus: hold `rst` for 3 cycles.
  - Response: `an`=FF and `seg`=FF during reset and for 3 cycles after release. On the 4th edge, `an`=FE and `seg`=C0.
- **Full scan:**
  - Stimulus: write 0x12345678.
  - Response: successive slots show (`an`,`seg`) = (FE,80), (FD,F8), (FB,82), (F7,92), (EF,99), (DF,B0), (BF,A4), (7F,F9), then wrap to (FE,80).
  - Each pair holds for exactly 4 cycles.
- **Write on a tick edge:**
  - Stimulus: data 0x0; write 0xFFFFFFFF on the edge where `tick`=1.
  - Response: that slot shows C0; the next slot shows 8E.
- **Reset mid-scan:**
  - Stimulus: assert `rst` while digit 5 is lit, with `seg7_cs`=1 on the same edge.
  - Response: next edge gives `an`=FF and `seg`=FF. After release, digit 0 shows C0 (data cleared, write ignored).
- **Back-to-back writes:**
  - Stimulus: `seg7_cs`=1 for 3 cycles with data 0x1, 0x2, 0xA.
  - Response: digit 0 subsequently shows 88.
- **Zero blanking (`SEG7_ZERO_BLANK_EN`):**
  - Stimulus: write 0x000000A0.
  - Response: digit 0 = C0, digit 1 = 88, digits 2–7 = FF.
  - Stimulus: write 0x0.
  - Response: digit 0 = C0, all others FF.
  - Without the macro, the same writes show C0 on every zero digit.
